buzzer_sched: RTL and testbench

Request scheduler in front of the buzzer driver: several independent sources (key click, alarm, fault, remote command) request beep patterns, and this block arbitrates among them and sequences the shared buzzer driver. It produces the driver's `BUZZER_EN` trigger edge and `BUZZER_SEL` length select. Each beep is timed with its own counters, matched to the driver's fixed tone period, because the driver provides no completion feedback. It sits between the front-panel/system control logic and the buzzer driver in the `CLK_LOW` domain.

---
 rtl/buzzer_pkg.sv | 30 +++
 rtl/prio_onehot.sv | 21 ++
 rtl/buzzer_sched.sv | 231 +++++++++++++++++++++++
 tb/tb_buzzer_sched.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/buzzer_pkg.sv
// Shared definitions for the buzzer scheduler and the buzzer driver.
//
// Contents:
//   state_t          - scheduler FSM states (IDLE, ARB, BEEP, GAP)
//   DEF_TONE_CYC     - CLK_LOW cycles per driver tone period
//   DEF_SHORT_UNITS  - tone periods per short beep
//   DEF_LONG_UNITS   - tone periods per long beep
//   DEF_GAP_UNITS    - tone periods of silence after every beep
//   units_last()     - last value of the 8-bit unit counter for a length
package buzzer_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARB  = 2'd1,
        S_BEEP = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    // These must stay equal to the driver's own timing constants.
    localparam int DEF_TONE_CYC    = 12500;
    localparam int DEF_SHORT_UNITS = 4;
    localparam int DEF_LONG_UNITS  = 255;
    localparam int DEF_GAP_UNITS   = 8;

    // Unit counter runs 0..units-1; this is the terminal value.
    function automatic logic [7:0] units_last(input int units);
        return 8'(units - 1);
    endfunction

endpackage

// File: rtl/prio_onehot.sv
// Fixed-priority picker: selects the lowest-index set bit.
//
// Parameters:
//   W       - number of request bits
// Ports:
//   req     in  [W-1:0]  request vector
//   onehot  out [W-1:0]  one-hot lowest set bit of req (all-zero if none)
//   valid   out          any bit of req is set
module prio_onehot #(
    parameter int W = 4
) (
    input  logic [W-1:0] req,
    output logic [W-1:0] onehot,
    output logic         valid
);

    // Two's-complement trick: req & -req isolates the lowest set bit.
    assign onehot = req & (~req + W'(1));
    assign valid  = |req;

endmodule

// File: rtl/buzzer_sched.sv
// Buzzer request scheduler.
//
// Several sources request beep patterns; the block latches each request,
// arbitrates with fixed priority (index 0 highest) and sequences the shared
// buzzer driver with its own tone/unit timers, since the driver gives no
// completion feedback.
//
// Build option:
//   BUZZER_SCHED_PREEMPT_EN  when defined, a pending source with a lower
//                            index than the granted one ends the active
//                            pattern at the end of the current gap (no DONE).
//
// Ports (all in the CLK_LOW domain):
//   CLK_LOW     in              clock
//   RST         in              asynchronous active-high reset
//   REQ         in  [N_REQ-1:0]   per-source request pulse
//   REQ_LONG    in  [N_REQ-1:0]   beep type per source (1 = long)
//   REQ_REP     in  [2*N_REQ-1:0] 2-bit repeat field per source (beeps = field+1)
//   GRANT       out [N_REQ-1:0]   one-hot current owner, 0 when idle
//   BUSY        out             a pattern is running
//   DONE        out             1-cycle pulse in the last gap cycle of a pattern
//   BUZZER_EN   out             driver trigger, high for the whole beep
//   BUZZER_SEL  out             driver length select (1 = long)
//   STATE_DBG   out [1:0]       current FSM state (buzzer_pkg::state_t encoding)
//
// Handshake: REQ is a plain one-cycle pulse with no ready; a request is
// never refused, repeated requests from one source collapse into a single
// pending pattern carrying the most recent type and count.
module buzzer_sched
    import buzzer_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int TONE_CYC    = DEF_TONE_CYC,
    parameter int SHORT_UNITS = DEF_SHORT_UNITS,
    parameter int LONG_UNITS  = DEF_LONG_UNITS,
    parameter int GAP_UNITS   = DEF_GAP_UNITS
) (
    input  logic               CLK_LOW,
    input  logic               RST,
    input  logic [N_REQ-1:0]   REQ,
    input  logic [N_REQ-1:0]   REQ_LONG,
    input  logic [2*N_REQ-1:0] REQ_REP,
    output logic [N_REQ-1:0]   GRANT,
    output logic               BUSY,
    output logic               DONE,
    output logic               BUZZER_EN,
    output logic               BUZZER_SEL,
    output logic [1:0]         STATE_DBG
);

    localparam int TW = (TONE_CYC > 1) ? $clog2(TONE_CYC) : 1;
    localparam logic [TW-1:0] TONE_LAST  = TW'(TONE_CYC - 1);
    localparam logic [7:0]    SHORT_LAST = units_last(SHORT_UNITS);
    localparam logic [7:0]    LONG_LAST  = units_last(LONG_UNITS);
    localparam logic [7:0]    GAP_LAST   = units_last(GAP_UNITS);

    state_t             state;
    logic [N_REQ-1:0]   grant_r;
    logic               busy_r;
    logic               en_r;
    logic               sel_r;
    logic [1:0]         rem;
    logic [TW-1:0]      tone_cnt;
    logic [7:0]         unit_cnt;

    logic [N_REQ-1:0]   pend;
    logic [N_REQ-1:0]   long_q;
    logic [2*N_REQ-1:0] rep_q;

    // Arbitration looks at stored flags plus this cycle's requests, so a
    // request seen in IDLE reaches ARB on the very next edge.
    logic [N_REQ-1:0]   pend_eff;
    logic [N_REQ-1:0]   long_eff;
    logic [2*N_REQ-1:0] rep_eff;
    logic [N_REQ-1:0]   pick;
    logic               pick_valid;
    logic               win_long;
    logic [1:0]         win_rep;

    logic               tone_last;
    logic               beep_end;
    logic               gap_end;
    logic               preempt;

    assign pend_eff = pend | REQ;
    assign long_eff = (REQ & REQ_LONG) | (~REQ & long_q);

    always_comb begin
        rep_eff = rep_q;
        for (int i = 0; i < N_REQ; i++) begin
            if (REQ[i]) begin
                rep_eff[2*i +: 2] = REQ_REP[2*i +: 2];
            end
        end
    end

    prio_onehot #(.W(N_REQ)) u_pick (
        .req    (pend_eff),
        .onehot (pick),
        .valid  (pick_valid)
    );

    always_comb begin
        win_rep = 2'd0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick[i]) begin
                win_rep = rep_eff[2*i +: 2];
            end
        end
    end

    assign win_long  = |(pick & long_eff);

    assign tone_last = (tone_cnt == TONE_LAST);
    assign beep_end  = tone_last && (unit_cnt == (sel_r ? LONG_LAST : SHORT_LAST));
    assign gap_end   = tone_last && (unit_cnt == GAP_LAST);

`ifdef BUZZER_SCHED_PREEMPT_EN
    // grant_r - 1 is a mask of every index below the current owner.
    assign preempt = (rem != 2'd0) && (|(pend_eff & (grant_r - N_REQ'(1))));
`else
    assign preempt = 1'b0;
`endif

    // Pending flags: a request always sets (and overwrites type/count).
    // The granted source's flag is cleared when ARB ends, unless it
    // requests again in that same cycle, which queues a repeat.
    always_ff @(posedge CLK_LOW or posedge RST) begin
        if (RST) begin
            pend   <= '0;
            long_q <= '0;
            rep_q  <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (REQ[i]) begin
                    pend[i]          <= 1'b1;
                    long_q[i]        <= REQ_LONG[i];
                    rep_q[2*i +: 2]  <= REQ_REP[2*i +: 2];
                end else if (state == S_ARB && grant_r[i]) begin
                    pend[i] <= 1'b0;
                end
            end
        end
    end

    // Main sequencer. Grant, type and count are loaded on the edge that
    // enters ARB so GRANT/BUSY/BUZZER_SEL are visible during ARB and
    // BUZZER_SEL is settled a full cycle before BUZZER_EN rises.
    always_ff @(posedge CLK_LOW or posedge RST) begin
        if (RST) begin
            state    <= S_IDLE;
            grant_r  <= '0;
            busy_r   <= 1'b0;
            en_r     <= 1'b0;
            sel_r    <= 1'b0;
            rem      <= 2'd0;
            tone_cnt <= '0;
            unit_cnt <= 8'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    tone_cnt <= '0;
                    unit_cnt <= 8'd0;
                    if (pick_valid) begin
                        state   <= S_ARB;
                        grant_r <= pick;
                        sel_r   <= win_long;
                        rem     <= win_rep;
                        busy_r  <= 1'b1;
                    end
                end
                S_ARB: begin
                    state    <= S_BEEP;
                    en_r     <= 1'b1;
                    tone_cnt <= '0;
                    unit_cnt <= 8'd0;
                end
                S_BEEP: begin
                    if (beep_end) begin
                        state    <= S_GAP;
                        en_r     <= 1'b0;
                        tone_cnt <= '0;
                        unit_cnt <= 8'd0;
                    end else if (tone_last) begin
                        tone_cnt <= '0;
                        unit_cnt <= unit_cnt + 8'd1;
                    end else begin
                        tone_cnt <= tone_cnt + TW'(1);
                    end
                end
                S_GAP: begin
                    if (gap_end) begin
                        tone_cnt <= '0;
                        unit_cnt <= 8'd0;
                        if (rem != 2'd0 && !preempt) begin
                            rem   <= rem - 2'd1;
                            state <= S_BEEP;
                            en_r  <= 1'b1;
                        end else if (pick_valid) begin
                            state   <= S_ARB;
                            grant_r <= pick;
                            sel_r   <= win_long;
                            rem     <= win_rep;
                            busy_r  <= 1'b1;
                        end else begin
                            state   <= S_IDLE;
                            grant_r <= '0;
                            busy_r  <= 1'b0;
                        end
                    end else if (tone_last) begin
                        tone_cnt <= '0;
                        unit_cnt <= unit_cnt + 8'd1;
                    end else begin
                        tone_cnt <= tone_cnt + TW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // DONE is a decode of registered state only: last gap cycle of the
    // final beep. A preempted pattern leaves with rem nonzero, so no DONE.
    assign DONE       = (state == S_GAP) && gap_end && (rem == 2'd0);
    assign GRANT      = grant_r;
    assign BUSY       = busy_r;
    assign BUZZER_EN  = en_r;
    assign BUZZER_SEL = sel_r;
    assign STATE_DBG  = state;

endmodule

// File: tb/tb_buzzer_sched.sv
// Directed testbench for buzzer_sched with scaled timing
// (TONE_CYC=10, SHORT_UNITS=4, LONG_UNITS=6, GAP_UNITS=2).
// Expected behaviour of BUZZER_SCHED_PREEMPT_EN follows the same macro.
module tb_buzzer_sched;
    import buzzer_pkg::*;

    logic       CLK_LOW;
    logic       RST;
    logic [3:0] REQ;
    logic [3:0] REQ_LONG;
    logic [7:0] REQ_REP;
    logic [3:0] GRANT;
    logic       BUSY;
    logic       DONE;
    logic       BUZZER_EN;
    logic       BUZZER_SEL;
    logic [1:0] STATE_DBG;

    int n_checks = 0;
    int n_err    = 0;
    int done_cnt = 0;
    int d0;
    int n;

    // Expected grant order, consumed by the ARB monitor.
    logic [3:0] exp_q[$];

    buzzer_sched #(
        .N_REQ       (4),
        .TONE_CYC    (10),
        .SHORT_UNITS (4),
        .LONG_UNITS  (6),
        .GAP_UNITS   (2)
    ) dut (
        .CLK_LOW    (CLK_LOW),
        .RST        (RST),
        .REQ        (REQ),
        .REQ_LONG   (REQ_LONG),
        .REQ_REP    (REQ_REP),
        .GRANT      (GRANT),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .BUZZER_EN  (BUZZER_EN),
        .BUZZER_SEL (BUZZER_SEL),
        .STATE_DBG  (STATE_DBG)
    );

    // ---------------- clock ----------------
    initial CLK_LOW = 1'b0;
    always #5 CLK_LOW = ~CLK_LOW;

    // ---------------- helpers / driver tasks ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int cycles);
        repeat (cycles) @(posedge CLK_LOW);
        #1;
    endtask

    task automatic pulse(input logic [3:0] r, input logic [3:0] l, input logic [7:0] rp);
        REQ      = r;
        REQ_LONG = l;
        REQ_REP  = rp;
        step(1);
        REQ      = '0;
        REQ_LONG = '0;
        REQ_REP  = '0;
    endtask

    // Count cycles BUZZER_EN stays at lvl (bounded).
    task automatic measure(input logic lvl, output int cnt);
        cnt = 0;
        while (BUZZER_EN === lvl && cnt < 1000) begin
            step(1);
            cnt++;
        end
    endtask

    // ---------------- monitors / scoreboard ----------------
    always @(negedge CLK_LOW) begin
        if (DONE === 1'b1) done_cnt++;
    end

    always @(negedge CLK_LOW) begin
        if (RST === 1'b0 && STATE_DBG === S_ARB) begin
            if (exp_q.size() == 0)
                chk("arb_unexpected", 32'(exp_q.size()), 32'd1);
            else
                chk("grant_order", 32'(GRANT), 32'(exp_q.pop_front()));
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        RST      = 1'b1;
        REQ      = '0;
        REQ_LONG = '0;
        REQ_REP  = '0;
        step(3);
        chk("rst_grant", 32'(GRANT), 32'd0);
        chk("rst_busy",  32'(BUSY), 32'd0);
        chk("rst_done",  32'(DONE), 32'd0);
        chk("rst_en",    32'(BUZZER_EN), 32'd0);
        chk("rst_sel",   32'(BUZZER_SEL), 32'd0);
        chk("rst_state", 32'(STATE_DBG), 32'(S_IDLE));
        RST = 1'b0;
        step(2);
        chk("idle_after_rst", 32'(STATE_DBG), 32'(S_IDLE));

        // Single short beep from source 1.
        exp_q.push_back(4'b0010);
        d0 = done_cnt;
        pulse(4'b0010, 4'b0000, 8'h00);            // now t+1
        chk("s_grant",  32'(GRANT), 32'h2);
        chk("s_busy",   32'(BUSY), 32'd1);
        chk("s_state",  32'(STATE_DBG), 32'(S_ARB));
        chk("s_en_arb", 32'(BUZZER_EN), 32'd0);
        step(1);                                   // t+2
        chk("s_en_rise", 32'(BUZZER_EN), 32'd1);
        chk("s_sel",     32'(BUZZER_SEL), 32'd0);
        measure(1'b1, n);                          // t+42
        chk("s_beep_len", 32'(n), 32'd40);
        chk("s_gap_state", 32'(STATE_DBG), 32'(S_GAP));
        step(19);                                  // t+61
        chk("s_done", 32'(DONE), 32'd1);
        chk("s_busy_last", 32'(BUSY), 32'd1);
        step(1);                                   // t+62
        chk("s_busy_off", 32'(BUSY), 32'd0);
        chk("s_grant_off", 32'(GRANT), 32'd0);
        chk("s_done_off", 32'(DONE), 32'd0);
        chk("s_done_cnt", 32'(done_cnt - d0), 32'd1);

        // Long x3 from source 2.
        exp_q.push_back(4'b0100);
        d0 = done_cnt;
        pulse(4'b0100, 4'b0100, 8'h20);
        chk("l_grant", 32'(GRANT), 32'h4);
        chk("l_sel_arb", 32'(BUZZER_SEL), 32'd1);
        step(1);
        for (int k = 0; k < 3; k++) begin
            chk("l_sel", 32'(BUZZER_SEL), 32'd1);
            measure(1'b1, n);
            chk("l_beep_len", 32'(n), 32'd60);
            if (k < 2) begin
                measure(1'b0, n);
                chk("l_gap_len", 32'(n), 32'd20);
            end
        end
        step(19);                                  // t+241
        chk("l_done", 32'(DONE), 32'd1);
        step(1);
        chk("l_idle", 32'(STATE_DBG), 32'(S_IDLE));
        chk("l_done_cnt", 32'(done_cnt - d0), 32'd1);

        // Simultaneous requests 1 and 3.
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b1000);
        d0 = done_cnt;
        pulse(4'b1010, 4'b0000, 8'h00);            // t+1
        chk("m_grant1", 32'(GRANT), 32'h2);
        step(60);                                  // t+61
        chk("m_done1", 32'(DONE), 32'd1);
        chk("m_grant1_hold", 32'(GRANT), 32'h2);
        step(1);                                   // t+62
        chk("m_grant3", 32'(GRANT), 32'h8);
        chk("m_arb", 32'(STATE_DBG), 32'(S_ARB));
        step(1);                                   // t+63
        chk("m_en3", 32'(BUZZER_EN), 32'd1);
        step(59);                                  // t+122
        chk("m_done3", 32'(DONE), 32'd1);
        step(1);
        chk("m_idle", 32'(STATE_DBG), 32'(S_IDLE));
        chk("m_done_cnt", 32'(done_cnt - d0), 32'd2);

        // Request during its own ARB cycle: set wins, one queued repeat.
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0010);
        d0 = done_cnt;
        pulse(4'b0010, 4'b0000, 8'h00);            // t+1 (ARB)
        pulse(4'b0010, 4'b0000, 8'h00);            // t+2
        step(59);                                  // t+61
        chk("a_done1", 32'(DONE), 32'd1);
        step(1);                                   // t+62
        chk("a_rearb", 32'(STATE_DBG), 32'(S_ARB));
        step(61);                                  // t+123
        chk("a_idle", 32'(STATE_DBG), 32'(S_IDLE));
        chk("a_done_cnt", 32'(done_cnt - d0), 32'd2);

        // Re-request during own BEEP: exactly one repeat.
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0001);
        d0 = done_cnt;
        pulse(4'b0001, 4'b0000, 8'h00);            // t+1
        step(5);                                   // t+6
        pulse(4'b0001, 4'b0000, 8'h00);            // t+7
        step(3);                                   // t+10
        pulse(4'b0001, 4'b0000, 8'h00);            // t+11
        step(50);                                  // t+61
        chk("r_done1", 32'(DONE), 32'd1);
        step(1);                                   // t+62
        chk("r_rearb", 32'(STATE_DBG), 32'(S_ARB));
        chk("r_grant", 32'(GRANT), 32'h1);
        step(61);                                  // t+123
        chk("r_idle", 32'(STATE_DBG), 32'(S_IDLE));
        chk("r_done_cnt", 32'(done_cnt - d0), 32'd2);

        // Source 3 with 4 beeps, source 0 arrives during beep 1.
        exp_q.push_back(4'b1000);
        exp_q.push_back(4'b0001);
        d0 = done_cnt;
        pulse(4'b1000, 4'b0000, 8'hC0);            // t+1
        step(5);                                   // t+6
        pulse(4'b0001, 4'b0000, 8'h00);            // t+7
        step(54);                                  // t+61
        chk("p_no_done_gap1", 32'(DONE), 32'd0);
        step(1);                                   // t+62
`ifdef BUZZER_SCHED_PREEMPT_EN
        chk("p_grant0", 32'(GRANT), 32'h1);
        chk("p_arb", 32'(STATE_DBG), 32'(S_ARB));
        step(61);                                  // t+123
        chk("p_idle", 32'(STATE_DBG), 32'(S_IDLE));
        chk("p_done_cnt", 32'(done_cnt - d0), 32'd1);
`else
        chk("p_grant3_keep", 32'(GRANT), 32'h8);
        chk("p_beep2", 32'(BUZZER_EN), 32'd1);
        step(179);                                 // t+241
        chk("p_done3", 32'(DONE), 32'd1);
        step(1);                                   // t+242
        chk("p_grant0", 32'(GRANT), 32'h1);
        step(61);                                  // t+303
        chk("p_idle", 32'(STATE_DBG), 32'(S_IDLE));
        chk("p_done_cnt", 32'(done_cnt - d0), 32'd2);
`endif

        // Reset in the middle of a beep, with another source pending.
        exp_q.push_back(4'b0100);
        pulse(4'b0100, 4'b0000, 8'h00);            // t+1
        step(1);                                   // t+2
        pulse(4'b1000, 4'b0000, 8'h00);            // t+3
        step(14);                                  // t+17, beep cycle 15
        chk("x_en_before", 32'(BUZZER_EN), 32'd1);
        RST = 1'b1;
        #1;
        chk("x_en_async", 32'(BUZZER_EN), 32'd0);
        chk("x_grant_async", 32'(GRANT), 32'd0);
        chk("x_busy_async", 32'(BUSY), 32'd0);
        step(2);
        RST = 1'b0;
        step(30);
        chk("x_idle", 32'(STATE_DBG), 32'(S_IDLE));
        chk("x_busy", 32'(BUSY), 32'd0);
        chk("x_en", 32'(BUZZER_EN), 32'd0);

        chk("grant_q_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
